// File: rtl/touch_pkg.sv
// Shared definitions for the touchscreen ADC responder and its initiator:
// frame geometry, FSM state encoding and a saturating counter helper.
package touch_pkg;

  localparam int unsigned DATA_W    = 12;
  localparam int unsigned LEAD_Z    = 4;
  localparam int unsigned FRAME_LEN = LEAD_Z + DATA_W;
  localparam int unsigned CNT_W     = 5;
  localparam int unsigned ABORT_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  function automatic logic [ABORT_W-1:0] sat_inc(input logic [ABORT_W-1:0] v);
    return (v == '1) ? v : v + ABORT_W'(1);
  endfunction

endpackage

// File: rtl/touch_adc_responder_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, followed by a history flop
// producing single-cycle rise/fall pulses. Pulses appear in the cycle after
// the second synchronizer stage updates, so a consumer registering them acts
// three clock edges after the pin moved.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchronizer chain and edge history; reset to the pin's idle level so
  // leaving reset never fabricates an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/touch_adc_responder.sv
// Serial responder for a touchscreen ADC initiator. On chip-select assertion
// both channel samples are captured as zero-padded frames and shifted out MSB
// first, advancing on each sclk falling edge so the initiator samples on the
// rising edge. Frames cut short by chip-select release are counted.
module touch_adc_responder #(
  parameter int unsigned DATA_W = touch_pkg::DATA_W,
  parameter int unsigned LEAD_Z = touch_pkg::LEAD_Z
) (
  input  logic              clk50,
  input  logic              reset,
  input  logic              sclk,
  input  logic              nCS,
  input  logic [DATA_W-1:0] sample1,
  input  logic [DATA_W-1:0] sample2,
  output logic              sdata1,
  output logic              sdata2,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        abort_cnt
);

  import touch_pkg::*;

  localparam int unsigned FLEN = LEAD_Z + DATA_W;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FLEN - 1);

  logic sclk_fall;
  logic sclk_rise_unused;
  logic cs_rise;
  logic cs_fall;

  state_e             state_q, state_d;
  logic [FLEN-1:0]    sr1_q, sr1_d;
  logic [FLEN-1:0]    sr2_q, sr2_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fd_q, fd_d;
  logic [ABORT_W-1:0] abort_q, abort_d;

  sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk    (clk50),
    .rst_n  (reset),
    .d_i    (sclk),
    .rise_o (sclk_rise_unused),
    .fall_o (sclk_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_ncs_sync (
    .clk    (clk50),
    .rst_n  (reset),
    .d_i    (nCS),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // Frame state, shift registers, bit counter, done pulse and abort counter.
  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sr1_q   <= '0;
      sr2_q   <= '0;
      cnt_q   <= '0;
      fd_q    <= 1'b0;
      abort_q <= '0;
    end else begin
      state_q <= state_d;
      sr1_q   <= sr1_d;
      sr2_q   <= sr2_d;
      cnt_q   <= cnt_d;
      fd_q    <= fd_d;
      abort_q <= abort_d;
    end
  end

  // Next-state logic: a chip-select fall (from IDLE or HOLD) loads a fresh
  // frame; in SHIFT a chip-select rise outranks any coincident sclk edge.
  always_comb begin
    state_d = state_q;
    sr1_d   = sr1_q;
    sr2_d   = sr2_q;
    cnt_d   = cnt_q;
    fd_d    = 1'b0;
    abort_d = abort_q;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          sr1_d   = {{LEAD_Z{1'b0}}, sample1};
          sr2_d   = {{LEAD_Z{1'b0}}, sample2};
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          sr1_d   = '0;
          sr2_d   = '0;
          abort_d = sat_inc(abort_q);
        end else if (sclk_fall) begin
          sr1_d = {sr1_q[FLEN-2:0], 1'b0};
          sr2_d = {sr2_q[FLEN-2:0], 1'b0};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            state_d = HOLD;
            fd_d    = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cs_fall) begin
          state_d = SHIFT;
          sr1_d   = {{LEAD_Z{1'b0}}, sample1};
          sr2_d   = {{LEAD_Z{1'b0}}, sample2};
          cnt_d   = '0;
        end else if (cs_rise) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign sdata1     = (state_q == SHIFT) ? sr1_q[FLEN-1] : 1'b0;
  assign sdata2     = (state_q == SHIFT) ? sr2_q[FLEN-1] : 1'b0;
  assign busy       = (state_q == SHIFT);
  assign frame_done = fd_q;
  assign abort_cnt  = abort_q;

endmodule

// File: tb/tb_touch_adc_responder.sv
// Bench for touch_adc_responder: an initiator drives sclk/nCS, a
// transaction-level model tracks what each output must be, and a per-cycle
// monitor compares the DUT against it once the synchronizers have settled.
module tb_touch_adc_responder;

  localparam int FL = 16;

  logic        clk50  = 1'b0;
  logic        reset  = 1'b0;
  logic        sclk   = 1'b0;
  logic        nCS    = 1'b1;
  logic [11:0] sample1 = '0;
  logic [11:0] sample2 = '0;
  logic        sdata1;
  logic        sdata2;
  logic        busy;
  logic        frame_done;
  logic [7:0]  abort_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_chg = 0;

  // Model: a frame is open from nCS low until nCS high; it serves FL bits.
  bit          m_in_frame = 1'b0;
  int          m_bits = 0;
  logic [15:0] m_w1 = '0;
  logic [15:0] m_w2 = '0;
  int          m_abort = 0;
  int          m_fd = 0;
  int          seen_fd = 0;

  touch_adc_responder #(.DATA_W(12), .LEAD_Z(4)) dut (
    .clk50      (clk50),
    .reset      (reset),
    .sclk       (sclk),
    .nCS        (nCS),
    .sample1    (sample1),
    .sample2    (sample2),
    .sdata1     (sdata1),
    .sdata2     (sdata2),
    .busy       (busy),
    .frame_done (frame_done),
    .abort_cnt  (abort_cnt)
  );

  always #5 clk50 = ~clk50;

  always @(posedge clk50) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic m_active();
    return m_in_frame && (m_bits < FL);
  endfunction

  function automatic logic m_bit(input logic [15:0] w);
    if (m_active()) return w[FL-1-m_bits];
    return 1'b0;
  endfunction

  // Per-cycle comparison once every pin change is at least 4 cycles old.
  always @(negedge clk50) begin
    if (frame_done === 1'b1) seen_fd++;
    if (reset === 1'b1 && (cyc - last_chg) >= 4) begin
      chk("busy", {31'b0, busy}, {31'b0, m_active()});
      chk("sdata1", {31'b0, sdata1}, {31'b0, m_bit(m_w1)});
      chk("sdata2", {31'b0, sdata2}, {31'b0, m_bit(m_w2)});
      chk("abort_cnt", {24'b0, abort_cnt}, m_abort);
      chk("frame_done_idle", {31'b0, frame_done}, 32'd0);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk50);
    #1;
  endtask

  task automatic set_ncs(input logic v);
    if (v == 1'b0) begin
      m_in_frame = 1'b1;
      m_bits     = 0;
      m_w1       = {4'b0, sample1};
      m_w2       = {4'b0, sample2};
    end else begin
      if (m_active()) m_abort = (m_abort < 255) ? m_abort + 1 : 255;
      m_in_frame = 1'b0;
    end
    nCS = v;
    last_chg = cyc;
  endtask

  task automatic sclk_up(output logic b1, output logic b2);
    b1 = sdata1;
    b2 = sdata2;
    chk("bit_sdata1", {31'b0, b1}, {31'b0, m_bit(m_w1)});
    chk("bit_sdata2", {31'b0, b2}, {31'b0, m_bit(m_w2)});
    sclk = 1'b1;
    last_chg = cyc;
  endtask

  task automatic sclk_down();
    if (m_active()) begin
      m_bits++;
      if (m_bits == FL) m_fd++;
    end
    sclk = 1'b0;
    last_chg = cyc;
  endtask

  task automatic do_reset_pulse();
    reset = 1'b0;
    nCS   = 1'b1;
    last_chg = cyc;
    m_in_frame = 1'b0;
    m_bits  = 0;
    m_abort = 0;
    @(negedge clk50);
    chk("rst_sdata1", {31'b0, sdata1}, 32'd0);
    chk("rst_sdata2", {31'b0, sdata2}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
    chk("rst_abort_cnt", {24'b0, abort_cnt}, 32'd0);
    wait_cyc(2);
    reset = 1'b1;
    last_chg = cyc;
  endtask

  // One initiator transaction. chg_at: bit index at which the samples change
  // (-1 = never); rst_at: reset after that many bits (0 = never).
  task automatic do_frame(input int nbits, input int half, input int chg_at,
                          input int rst_at, input int gap,
                          output logic [31:0] rd1, output logic [31:0] rd2);
    logic b1, b2;
    rd1 = '0;
    rd2 = '0;
    set_ncs(1'b0);
    wait_cyc(half);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_at) begin
        sample1 = 12'hFFF;
        sample2 = 12'($urandom);
      end
      sclk_up(b1, b2);
      rd1 = {rd1[30:0], b1};
      rd2 = {rd2[30:0], b2};
      wait_cyc(half);
      sclk_down();
      wait_cyc(half);
      if (i + 1 == rst_at) begin
        do_reset_pulse();
        wait_cyc(gap);
        return;
      end
    end
    set_ncs(1'b1);
    wait_cyc(gap);
    chk("frame_done_count", seen_fd, m_fd);
  endtask

  initial begin
    logic [31:0] r1, r2;
    int nb;
    int ch;

    // Power-on reset: everything zero, no false edges afterwards.
    wait_cyc(1);
    @(negedge clk50);
    chk("por_sdata1", {31'b0, sdata1}, 32'd0);
    chk("por_busy", {31'b0, busy}, 32'd0);
    chk("por_frame_done", {31'b0, frame_done}, 32'd0);
    chk("por_abort_cnt", {24'b0, abort_cnt}, 32'd0);
    wait_cyc(2);
    reset = 1'b1;
    last_chg = cyc;
    wait_cyc(10);

    // Nominal frame.
    sample1 = 12'hABC;
    sample2 = 12'h123;
    do_frame(16, 10, -1, 0, 10, r1, r2);
    chk("nominal_sdata1", r1, 32'h0ABC);
    chk("nominal_sdata2", r2, 32'h0123);
    chk("nominal_fd", seen_fd, 32'd1);

    // Samples changing mid-frame do not disturb the frame.
    sample1 = 12'hABC;
    sample2 = 12'h123;
    do_frame(16, 10, 5, 0, 10, r1, r2);
    chk("late_change_sdata1", r1, 32'h0ABC);
    chk("late_change_sdata2", r2, 32'h0123);

    // Twenty clocks: the last four read zero, still one frame_done.
    sample1 = 12'hABC;
    sample2 = 12'h123;
    do_frame(20, 10, -1, 0, 10, r1, r2);
    chk("extra_sdata1", r1, 32'h0ABC0);
    chk("extra_sdata2", r2, 32'h01230);
    chk("extra_fd", seen_fd, 32'd3);

    // Abort after seven clocks.
    do_frame(7, 10, -1, 0, 10, r1, r2);
    chk("abort_sdata1", r1, 32'h05);
    chk("abort_sdata2", r2, 32'h00);
    chk("abort_cnt_one", {24'b0, abort_cnt}, 32'd1);
    chk("abort_no_fd", seen_fd, 32'd3);
    chk("abort_sdata_idle", {30'b0, sdata1, sdata2}, 32'd0);

    // Back-to-back frames with an 8-cycle deselect gap.
    sample1 = 12'h321;
    sample2 = 12'h456;
    do_frame(16, 10, -1, 0, 8, r1, r2);
    chk("b2b_a_sdata1", r1, 32'h0321);
    chk("b2b_a_sdata2", r2, 32'h0456);
    sample1 = 12'h789;
    sample2 = 12'hDEF;
    do_frame(16, 10, -1, 0, 10, r1, r2);
    chk("b2b_b_sdata1", r1, 32'h0789);
    chk("b2b_b_sdata2", r2, 32'h0DEF);

    // Randomized frames: lengths around the frame size, varied sclk rates.
    for (int k = 0; k < 40; k++) begin
      sample1 = 12'($urandom);
      sample2 = 12'($urandom);
      nb = int'($urandom_range(1, 20));
      ch = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
      do_frame(nb, int'($urandom_range(4, 12)), ch, 0,
               int'($urandom_range(5, 15)), r1, r2);
    end

    // Abort counter saturates.
    for (int k = 0; k < 260; k++) begin
      do_frame(1, 5, -1, 0, 5, r1, r2);
    end
    chk("abort_cnt_sat", {24'b0, abort_cnt}, 32'd255);

    // Reset during bit 9 clears everything without counting an abort.
    sample1 = 12'hABC;
    sample2 = 12'h123;
    do_frame(16, 10, -1, 9, 10, r1, r2);
    chk("midrst_partial_sdata1", r1, 32'h015);
    chk("midrst_abort_cnt", {24'b0, abort_cnt}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    sample1 = 12'h5A5;
    sample2 = 12'hF0F;
    do_frame(16, 10, -1, 0, 10, r1, r2);
    chk("post_rst_sdata1", r1, 32'h05A5);
    chk("post_rst_sdata2", r2, 32'h0F0F);
    chk("post_rst_abort_cnt", {24'b0, abort_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
